sp_ram_bist: RTL and testbench
==============================

Name: sp_ram_bist

Overview:
- March C- built-in self-test controller that drives the pin interface of `sp_ram_asic` as the initiator: A, DI, BW, CE, RDWEN out; DO in.
- Sits between the functional user and the RAM macro wrapper.
- When idle, functional pins pass straight through to the RAM.
- When running, the controller owns the RAM, checks every read, and reports pass/fail plus the first failing address and march element.

Parameters:
- ADDR_WIDTH, 1, RAM address width; depth N = 2**ADDR_WIDTH.
- DATA_WIDTH, 1, RAM word width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  begin test; sampled only in IDLE or DONE state.
- F_A  in  ADDR_WIDTH  functional address.
- F_DI  in  DATA_WIDTH  functional write data.
- F_BW  in  DATA_WIDTH  functional bit-write mask.
- F_CE  in  1  functional chip enable.
- F_RDWEN  in  1  functional 1=WR, 0=RD.
- F_DO  out  DATA_WIDTH  functional read data (= DO).
- A  out  ADDR_WIDTH  to RAM.
- DI  out  DATA_WIDTH  to RAM.
- BW  out  DATA_WIDTH  to RAM.
- CE  out  1  to RAM.
- RDWEN  out  1  to RAM (1=WR, 0=RD).
- DO  in  DATA_WIDTH  from RAM; valid the cycle after a read access.
- BUSY  out  1  test running.
- DONE  out  1  test complete, sticky.
- FAIL  out  1  at least one miscompare, sticky.
- FAIL_ADDR  out  ADDR_WIDTH  address of first miscompare.
- FAIL_ELEM  out  3  march element (0-5) of first miscompare.

Behaviour:
- Reset values:
  - BUSY, DONE, FAIL = 0; FAIL_ADDR = 0; FAIL_ELEM = 0; state IDLE.
  - RAM pins follow the functional inputs (mux select = BUSY = 0).
- Mux:
  - BUSY=0: A/DI/BW/CE/RDWEN = F_*.
  - BUSY=1: controller drives them and functional inputs are ignored.
  - F_DO = DO always.
- States: IDLE, M0..M5, DONE.
- Element sequence (0 = all-zeros word, 1 = all-ones word, BW = all ones throughout):
  - M0 ⇑ w0.
  - M1 ⇑ (r0, w1).
  - M2 ⇑ (r1, w0).
  - M3 ⇓ (r0, w1).
  - M4 ⇓ (r1, w0).
  - M5 ⇑ r0.
- Access pacing:
  - One RAM access per cycle, CE=1 every BUSY cycle.
  - Read/write pairs: read at addr in cycle t, write same addr in cycle t+1.
- Address order:
  - ⇑ runs 0..N-1; ⇓ runs N-1..0.
  - At the last address the next element starts on the next cycle with no bubble.
- Start timing:
  - START=1 sampled in IDLE or DONE → next cycle BUSY=1, DONE=0, FAIL=0, FAIL_ADDR/ELEM=0, first M0 write issued that cycle.
  - START while BUSY is ignored.
- Compare path:
  - For a read issued in cycle t, DO is compared in cycle t+1 against the expected word registered at t.
  - A miscompare is flagged at the end of t+1.
  - The comparator is pipeline-registered: expected data, address and element are delayed 1 cycle alongside the read-valid flag.
- Failure capture:
  - On the first miscompare: FAIL=1, FAIL_ADDR and FAIL_ELEM latched.
  - Later miscompares do not overwrite them.
  - The test always runs to completion.
- Completion:
  - Total RAM accesses = 10N.
  - BUSY stays high one extra cycle to drain the final M5 compare, so BUSY is high for exactly 10N+1 cycles.
  - Then BUSY=0, DONE=1, state DONE.
  - DONE, FAIL, FAIL_ADDR and FAIL_ELEM hold until the next accepted START or RST.
- Reset mid-test:
  - RST=1 in any cycle returns to reset values next edge.
  - The RAM is released to functional pins immediately after that edge.
  - Partial RAM contents are undefined.
- N=2 (ADDR_WIDTH=1) must work; the address counter wraps without overflow side effects.

Decomposition:
- Package sp_ram_bist_pkg holds:
  - state enum (IDLE, M0-M5, DONE);
  - 3-bit element codes;
  - per-element direction bit, read-expect bit and write-data bit tables.
- Sub-module sp_ram_bist_addr_gen: loadable up/down address counter with `last` flag; load value is 0 for ⇑ and N-1 for ⇓.

Test Plan:
- Defaults for all scenarios: ADDR_WIDTH=3, DATA_WIDTH=8, behavioural sync RAM model.
- Fault-free: pulse START → BUSY high exactly 81 cycles, then DONE=1, FAIL=0; access trace shows 80 CE cycles with the exact March C- order and addresses.
- Stuck-at-1 on bit0 of addr 5 → FAIL=1, FAIL_ADDR=5, FAIL_ELEM=1, DONE after 81 cycles.
- Stuck-at-0 on bit7 of addr 2 → FAIL_ADDR=2, FAIL_ELEM=2; a second fault at addr 6 does not change the captured values.
- Bypass: with BUSY=0, functional write 0xA5 to addr 3 then read → F_DO=0xA5 the cycle after the read; START pulsed mid-test is ignored.
- RST asserted at cycle 40 of the test → next cycle BUSY=DONE=FAIL=0 and RAM pins equal F_*; a new START runs the full 81 cycles.
- ADDR_WIDTH=1 fault-free → BUSY 21 cycles, DONE=1, FAIL=0.

Source files
------------

// File: rtl/sp_ram_bist_pkg.sv
// Shared constants for the March C- RAM self-test: FSM state codes, element
// codes and the per-element direction / read / write tables.
package sp_ram_bist_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_M0    = 4'd1;
  localparam logic [3:0] ST_M1    = 4'd2;
  localparam logic [3:0] ST_M2    = 4'd3;
  localparam logic [3:0] ST_M3    = 4'd4;
  localparam logic [3:0] ST_M4    = 4'd5;
  localparam logic [3:0] ST_M5    = 4'd6;
  localparam logic [3:0] ST_DRAIN = 4'd7;
  localparam logic [3:0] ST_DONE  = 4'd8;

  typedef logic [2:0] elem_t;

  localparam elem_t ELEM_M0 = 3'd0;
  localparam elem_t ELEM_M5 = 3'd5;

  // Tables are indexed by element code; bits 6 and 7 are unused codes and stay 0.
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
  localparam logic [7:0] ELEM_HAS_RD  = 8'b0011_1110;
  localparam logic [7:0] ELEM_HAS_WR  = 8'b0001_1111;
  localparam logic [7:0] ELEM_RD_EXP  = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_DATA = 8'b0000_1010;

endpackage

// File: rtl/sp_ram_bist_addr_gen.sv
// Loadable up/down address counter for the march elements; `last` marks the
// final address in the direction chosen at load time.
module sp_ram_bist_addr_gen #(
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic down_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      addr   <= load_down ? '1 : '0;
      down_q <= load_down;
    end else if (step) begin
      addr <= down_q ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down_q ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sp_ram_bist.sv
// March C- BIST controller between the functional port and a single-port RAM;
// owns the RAM while BUSY and records the first miscompare.
module sp_ram_bist
  import sp_ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] F_A,
  input  logic [DATA_WIDTH-1:0] F_DI,
  input  logic [DATA_WIDTH-1:0] F_BW,
  input  logic                  F_CE,
  input  logic                  F_RDWEN,
  output logic [DATA_WIDTH-1:0] F_DO,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] DI,
  output logic [DATA_WIDTH-1:0] BW,
  output logic                  CE,
  output logic                  RDWEN,
  input  logic [DATA_WIDTH-1:0] DO,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FAIL,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]            FAIL_ELEM
);

  logic [3:0]            state_q;
  logic                  phase_q;   // 1 = write half of a read/write pair
  elem_t                 elem;
  logic                  in_march, busy_w, has_rd, has_wr, is_rd, is_wr;
  logic                  op_done, elem_end, start_ok, miscmp;
  logic [ADDR_WIDTH-1:0] bist_addr;
  logic                  addr_last, ag_load, ag_load_down, ag_step;

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;
  elem_t                 cmp_elem_q;

  logic                  done_q, fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  elem_t                 fail_elem_q;

  assign elem     = 3'(state_q - ST_M0);
  assign in_march = (state_q >= ST_M0) && (state_q <= ST_M5);
  assign busy_w   = in_march || (state_q == ST_DRAIN);
  assign has_rd   = ELEM_HAS_RD[elem];
  assign has_wr   = ELEM_HAS_WR[elem];
  assign is_rd    = in_march && has_rd && !phase_q;
  assign is_wr    = in_march && has_wr && (phase_q || !has_rd);
  assign op_done  = in_march && (!(has_rd && has_wr) || phase_q);
  assign elem_end = op_done && addr_last;
  assign start_ok = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign miscmp   = rd_valid_q && (DO != exp_q);

  // The next element's start address is loaded on the last op of the current
  // one, so consecutive elements run back to back.
  assign ag_load      = start_ok || (elem_end && (elem != ELEM_M5));
  assign ag_load_down = !start_ok && ELEM_DOWN[elem + 3'd1];
  assign ag_step      = op_done && !addr_last;

  sp_ram_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (CLK),
    .rst      (RST),
    .load     (ag_load),
    .load_down(ag_load_down),
    .step     (ag_step),
    .addr     (bist_addr),
    .last     (addr_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= ELEM_M0;
    end else begin
      rd_valid_q <= is_rd;
      if (start_ok) begin
        state_q     <= ST_M0;
        phase_q     <= 1'b0;
        done_q      <= 1'b0;
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= ELEM_M0;
      end else begin
        if (miscmp && !fail_q) begin
          fail_q      <= 1'b1;
          fail_addr_q <= cmp_addr_q;
          fail_elem_q <= cmp_elem_q;
        end
        if (in_march) begin
          phase_q <= has_rd && has_wr && !phase_q;
          if (elem_end) state_q <= (elem == ELEM_M5) ? ST_DRAIN : state_q + 4'd1;
        end else if (state_q == ST_DRAIN) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  // NOTE: compare-pipeline data registers carry no reset; they are only
  // consumed when rd_valid_q, which is reset, marks them valid.
  always_ff @(posedge CLK) begin
    exp_q      <= {DATA_WIDTH{ELEM_RD_EXP[elem]}};
    cmp_addr_q <= bist_addr;
    cmp_elem_q <= elem;
  end

  assign A     = busy_w ? bist_addr : F_A;
  assign DI    = busy_w ? {DATA_WIDTH{is_wr && ELEM_WR_DATA[elem]}} : F_DI;
  assign BW    = busy_w ? {DATA_WIDTH{1'b1}} : F_BW;
  assign CE    = busy_w ? in_march : F_CE;
  assign RDWEN = busy_w ? is_wr : F_RDWEN;
  assign F_DO  = DO;

  assign BUSY      = busy_w;
  assign DONE      = done_q;
  assign FAIL      = fail_q;
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_ELEM = fail_elem_q;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Directed and randomized bench for sp_ram_bist with a fault-injecting RAM
// model and an element-level March C- reference.
module tb_sp_ram_bist;

  typedef struct {
    bit         wr;
    int         addr;
    logic [7:0] data;
    logic [7:0] bw;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst, start, s_start;
  logic [2:0] f_a, a;
  logic [7:0] f_di, f_bw, f_do, di, bw, ram_do;
  logic       f_ce, f_rdwen, ce, rdwen;
  logic       busy, done, fail;
  logic [2:0] fail_addr, fail_elem;

  logic       s_f_a, s_a, s_fail_addr;
  logic [7:0] s_f_di, s_f_bw, s_f_do, s_di, s_bw, s_ram_do;
  logic       s_f_ce, s_f_rdwen, s_ce, s_rdwen, s_busy, s_done, s_fail;
  logic [2:0] s_fail_elem;

  logic [7:0] mem [8];
  logic [7:0] s_mem [2];

  bit fen [2];
  int fadr [2];
  int fbit [2];
  bit fval [2];

  int rd_exp [6] = '{-1, 0, 1, 0, 1, 0};
  int wr_val [6] = '{0, 1, 0, 1, 0, -1};
  bit el_down [6] = '{0, 0, 0, 1, 1, 0};

  acc_t exp_tr[$];
  acc_t got_tr[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sp_ram_bist #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) u_dut (
    .CLK(clk), .RST(rst), .START(start),
    .F_A(f_a), .F_DI(f_di), .F_BW(f_bw), .F_CE(f_ce), .F_RDWEN(f_rdwen), .F_DO(f_do),
    .A(a), .DI(di), .BW(bw), .CE(ce), .RDWEN(rdwen), .DO(ram_do),
    .BUSY(busy), .DONE(done), .FAIL(fail), .FAIL_ADDR(fail_addr), .FAIL_ELEM(fail_elem)
  );

  sp_ram_bist #(.ADDR_WIDTH(1), .DATA_WIDTH(8)) u_dut_small (
    .CLK(clk), .RST(rst), .START(s_start),
    .F_A(s_f_a), .F_DI(s_f_di), .F_BW(s_f_bw), .F_CE(s_f_ce), .F_RDWEN(s_f_rdwen), .F_DO(s_f_do),
    .A(s_a), .DI(s_di), .BW(s_bw), .CE(s_ce), .RDWEN(s_rdwen), .DO(s_ram_do),
    .BUSY(s_busy), .DONE(s_done), .FAIL(s_fail), .FAIL_ADDR(s_fail_addr), .FAIL_ELEM(s_fail_elem)
  );

  function automatic logic [7:0] faulty(input logic [7:0] v, input int addr);
    logic [7:0] r = v;
    for (int i = 0; i < 2; i++)
      if (fen[i] && fadr[i] == addr) r[fbit[i]] = fval[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ce) begin
      if (rdwen) mem[a] <= (mem[a] & ~bw) | (di & bw);
      else       ram_do <= faulty(mem[a], int'(a));
    end
    if (s_ce) begin
      if (s_rdwen) s_mem[s_a] <= (s_mem[s_a] & ~s_bw) | (s_di & s_bw);
      else         s_ram_do   <= s_mem[s_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_trace(input int n);
    acc_t e;
    exp_tr.delete();
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < n; i++) begin
        e.addr = el_down[el] ? n - 1 - i : i;
        e.bw   = 8'hFF;
        if (rd_exp[el] >= 0) begin
          e.wr = 1'b0; e.data = 8'h00; exp_tr.push_back(e);
        end
        if (wr_val[el] >= 0) begin
          e.wr = 1'b1; e.data = (wr_val[el] == 1) ? 8'hFF : 8'h00; exp_tr.push_back(e);
        end
      end
    end
  endtask

  task automatic model_fail(input int n, output bit f, output int fa, output int fe);
    logic [7:0] m [8];
    logic [7:0] v;
    f = 1'b0; fa = 0; fe = 0;
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < n; i++) begin
        int ad = el_down[el] ? n - 1 - i : i;
        if (rd_exp[el] >= 0) begin
          v = faulty(m[ad], ad);
          if (v !== ((rd_exp[el] == 1) ? 8'hFF : 8'h00) && !f) begin
            f = 1'b1; fa = ad; fe = el;
          end
        end
        if (wr_val[el] >= 0) m[ad] = (wr_val[el] == 1) ? 8'hFF : 8'h00;
      end
    end
  endtask

  task automatic compare_trace(input string tag);
    int bad = -1;
    check({tag, "_len"}, got_tr.size(), exp_tr.size());
    for (int i = 0; i < got_tr.size() && i < exp_tr.size(); i++) begin
      if (bad < 0 && (got_tr[i].wr !== exp_tr[i].wr || got_tr[i].addr != exp_tr[i].addr ||
                      got_tr[i].bw !== exp_tr[i].bw ||
                      (exp_tr[i].wr && got_tr[i].data !== exp_tr[i].data)))
        bad = i;
    end
    check({tag, "_first_bad_idx"}, bad, -1);
  endtask

  // Called at a negedge; returns at the negedge after BUSY drops, or right
  // after the reset edge when rst_at is reached (RST left asserted).
  task automatic run_big(input int rst_at, input int start_at, output int cycles,
                         output logic [1:0] flags0);
    acc_t e;
    got_tr.delete();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    flags0 = {done, fail};
    while (busy === 1'b1 && cycles < 300) begin
      if (ce) begin
        e.wr = rdwen; e.addr = int'(a); e.data = di; e.bw = bw;
        got_tr.push_back(e);
      end
      cycles++;
      start = (cycles == start_at);
      f_a = 3'($urandom); f_di = 8'($urandom); f_ce = 1'($urandom); f_rdwen = 1'($urandom);
      if (cycles == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_small(output int cycles);
    acc_t e;
    got_tr.delete();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cycles  = 0;
    while (s_busy === 1'b1 && cycles < 100) begin
      if (s_ce) begin
        e.wr = s_rdwen; e.addr = int'(s_a); e.data = s_di; e.bw = s_bw;
        got_tr.push_back(e);
      end
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic func_write(input int ad, input logic [7:0] d, input logic [7:0] m);
    f_ce = 1'b1; f_rdwen = 1'b1; f_a = 3'(ad); f_di = d; f_bw = m;
    @(negedge clk);
    f_ce = 1'b0;
  endtask

  task automatic func_read(input int ad, output logic [7:0] d);
    f_ce = 1'b1; f_rdwen = 1'b0; f_a = 3'(ad);
    @(negedge clk);
    f_ce = 1'b0;
    d = f_do;
  endtask

  initial begin
    int cyc, fa, fe;
    bit f;
    logic [1:0] flags0;
    logic [7:0] rd, d1, d2, m;
    int ad;

    rst = 1'b1; start = 1'b0; s_start = 1'b0;
    f_a = '0; f_di = '0; f_bw = '0; f_ce = 1'b0; f_rdwen = 1'b0;
    s_f_a = 1'b0; s_f_di = '0; s_f_bw = '0; s_f_ce = 1'b0; s_f_rdwen = 1'b0;
    for (int i = 0; i < 2; i++) begin fen[i] = 1'b0; fadr[i] = 0; fbit[i] = 0; fval[i] = 1'b0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and functional pass-through.
    check("rst_flags", {busy, done, fail}, 3'b000);
    check("rst_fail_info", {fail_addr, fail_elem}, 6'd0);
    check("rst_small_busy", {s_busy, s_done, s_fail}, 3'b000);
    f_a = 3'($urandom); f_di = 8'($urandom); f_bw = 8'($urandom); f_rdwen = 1'($urandom);
    #1;
    check("rst_mux_pins", {a, di, bw, ce, rdwen}, {f_a, f_di, f_bw, f_ce, f_rdwen});
    @(negedge clk);

    // Functional bypass access, including partial bit-write masks.
    func_write(3, 8'hA5, 8'hFF);
    func_read(3, rd);
    check("bypass_a5", rd, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      ad = $urandom_range(0, 7); d1 = 8'($urandom); d2 = 8'($urandom); m = 8'($urandom);
      func_write(ad, d1, 8'hFF);
      func_write(ad, d2, m);
      func_read(ad, rd);
      check($sformatf("bypass_mask_%0d", k), rd, (d1 & ~m) | (d2 & m));
    end

    // Fault-free run, START pulsed mid-test must be ignored.
    build_trace(8);
    f_bw = 8'h00;
    run_big(-1, 20, cyc, flags0);
    check("clean_busy_cycles", cyc, 81);
    check("clean_done_fail", {done, fail}, 2'b10);
    compare_trace("clean_trace");

    // Stuck-at-1, bit0 of address 5.
    fen[0] = 1'b1; fadr[0] = 5; fbit[0] = 0; fval[0] = 1'b1;
    run_big(-1, -1, cyc, flags0);
    check("sa1_busy_cycles", cyc, 81);
    check("sa1_done_fail", {done, fail}, 2'b11);
    check("sa1_fail_addr", fail_addr, 5);
    check("sa1_fail_elem", fail_elem, 1);

    // Stuck-at-0 at address 2 bit7 plus a later fault at address 6.
    fadr[0] = 2; fbit[0] = 7; fval[0] = 1'b0;
    fen[1] = 1'b1; fadr[1] = 6; fbit[1] = 3; fval[1] = 1'b0;
    run_big(-1, -1, cyc, flags0);
    check("sa0_start_clears", flags0, 2'b00);
    check("sa0_fail", {done, fail}, 2'b11);
    check("sa0_fail_addr", fail_addr, 2);
    check("sa0_fail_elem", fail_elem, 2);

    // Reset in cycle 40, then a full clean rerun.
    fen[0] = 1'b0; fen[1] = 1'b0;
    run_big(40, -1, cyc, flags0);
    check("midrst_flags", {busy, done, fail}, 3'b000);
    check("midrst_fail_info", {fail_addr, fail_elem}, 6'd0);
    #1;
    check("midrst_mux_pins", {a, di, bw, ce, rdwen}, {f_a, f_di, f_bw, f_ce, f_rdwen});
    rst = 1'b0; f_ce = 1'b0;
    @(negedge clk);
    run_big(-1, -1, cyc, flags0);
    check("rerun_busy_cycles", cyc, 81);
    check("rerun_done_fail", {done, fail}, 2'b10);
    compare_trace("rerun_trace");

    // Randomized single stuck-at faults against the march reference.
    for (int r = 0; r < 3; r++) begin
      fen[0] = 1'b1; fadr[0] = $urandom_range(0, 7); fbit[0] = $urandom_range(0, 7);
      fval[0] = 1'($urandom);
      model_fail(8, f, fa, fe);
      run_big(-1, -1, cyc, flags0);
      check($sformatf("rnd%0d_busy_cycles", r), cyc, 81);
      check($sformatf("rnd%0d_fail", r), {done, fail}, {1'b1, f});
      check($sformatf("rnd%0d_fail_addr", r), fail_addr, fa);
      check($sformatf("rnd%0d_fail_elem", r), fail_elem, fe);
    end
    fen[0] = 1'b0;

    // Two-word RAM.
    build_trace(2);
    run_small(cyc);
    check("small_busy_cycles", cyc, 21);
    check("small_done_fail", {s_done, s_fail}, 2'b10);
    compare_trace("small_trace");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
